// File: rtl/reg_scoreboard.sv
// Purpose: per-register in-flight write tracker between decode and writeback; raises RAW/WAW stalls.
// Latency: issue_ready/stall are same-cycle combinational; busy_vector/pending_total/err_sticky one cycle later.
// Backpressure: decode is held via issue_ready/stall; retire is never backpressured.
// Optional: define REG_SCOREBOARD_STATS_EN to build the saturating stall_cycles counter.
module reg_scoreboard #(
  parameter int NUM_REGS    = 32,
  parameter int ADDR_W      = 5,
  parameter int MAX_PENDING = 3
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                issue_valid,
  input  logic [ADDR_W-1:0]   issue_rs1,
  input  logic                issue_rs1_used,
  input  logic [ADDR_W-1:0]   issue_rs2,
  input  logic                issue_rs2_used,
  input  logic [ADDR_W-1:0]   issue_rd,
  input  logic                issue_rd_we,
  output logic                issue_ready,
  output logic                stall,
  input  logic                retire_valid,
  input  logic [ADDR_W-1:0]   retire_rd,
  input  logic                flush,
  output logic [NUM_REGS-1:0] busy_vector,
  output logic [7:0]          pending_total,
  output logic                err_sticky,
  output logic [31:0]         stall_cycles
);

  localparam int CNT_W = $clog2(MAX_PENDING + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_PENDING);

  // Outstanding-write count per register; entry 0 is held at zero (x0 is never tracked).
  logic [CNT_W-1:0] cnt     [NUM_REGS];
  logic [CNT_W-1:0] cnt_nxt [NUM_REGS];
  logic [NUM_REGS-1:0] busy_nxt;
  logic [7:0] pending_nxt;

  logic dec;
  logic inc;
  logic underflow;
  logic overflow;
  logic [CNT_W-1:0] eff_rs1;
  logic [CNT_W-1:0] eff_rs2;
  logic [CNT_W-1:0] eff_rd;
  logic raw1;
  logic raw2;
  logic waw;

  // Hazard detection using counts that already see this cycle's retire (regfile write-then-read bypass).
  always_comb begin
    dec       = retire_valid & (retire_rd != '0) & (cnt[retire_rd] != '0);
    underflow = retire_valid & (retire_rd != '0) & (cnt[retire_rd] == '0);

    eff_rs1 = cnt[issue_rs1] - CNT_W'(dec & (retire_rd == issue_rs1));
    eff_rs2 = cnt[issue_rs2] - CNT_W'(dec & (retire_rd == issue_rs2));
    eff_rd  = cnt[issue_rd]  - CNT_W'(dec & (retire_rd == issue_rd));

    raw1 = issue_rs1_used & (issue_rs1 != '0) & (eff_rs1 != '0);
    raw2 = issue_rs2_used & (issue_rs2 != '0) & (eff_rs2 != '0);
    waw  = issue_rd_we    & (issue_rd  != '0) & (eff_rd == CNT_MAX);

    issue_ready = ~(raw1 | raw2 | waw) & ~flush;
    stall       = issue_valid & ~issue_ready;

    inc = issue_valid & issue_ready & issue_rd_we & (issue_rd != '0);
    // Unreachable while the WAW check holds; kept as a guard so a counter never wraps silently.
    overflow = inc & (cnt[issue_rd] == CNT_MAX) & ~(dec & (retire_rd == issue_rd));
  end

  // Next-state counters: an issue and a retire on the same register cancel out.
  always_comb begin
    busy_nxt    = '0;
    pending_nxt = pending_total + {7'd0, inc} - {7'd0, dec};
    for (int r = 0; r < NUM_REGS; r++) begin
      cnt_nxt[r] = cnt[r];
      if (r == 0) begin
        cnt_nxt[r] = '0;
      end else begin
        if ((inc & (issue_rd == ADDR_W'(r))) && !(dec & (retire_rd == ADDR_W'(r)))) begin
          cnt_nxt[r] = cnt[r] + CNT_W'(1);
        end else if ((dec & (retire_rd == ADDR_W'(r))) && !(inc & (issue_rd == ADDR_W'(r)))) begin
          cnt_nxt[r] = cnt[r] - CNT_W'(1);
        end
        busy_nxt[r] = (cnt_nxt[r] != '0);
      end
    end
  end

  // State update: reset beats flush, flush discards this cycle's issue/retire and leaves err_sticky alone.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int r = 0; r < NUM_REGS; r++) cnt[r] <= '0;
      busy_vector   <= '0;
      pending_total <= '0;
      err_sticky    <= 1'b0;
    end else if (flush) begin
      for (int r = 0; r < NUM_REGS; r++) cnt[r] <= '0;
      busy_vector   <= '0;
      pending_total <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) cnt[r] <= cnt_nxt[r];
      busy_vector   <= busy_nxt;
      pending_total <= pending_nxt;
      if (underflow | overflow) err_sticky <= 1'b1;
    end
  end

`ifdef REG_SCOREBOARD_STATS_EN
  // Saturating count of stalled cycles; survives flush, cleared only by reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cycles <= '0;
    end else if (!flush && stall && (stall_cycles != 32'hFFFF_FFFF)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`else
  assign stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_reg_scoreboard.sv
// Purpose: randomized plus directed check of reg_scoreboard against a count-per-register reference model.
// Latency: combinational outputs sampled at negedge, registered outputs #1 after posedge.
// Backpressure: stimulus holds nothing; each cycle's acceptance is decided by the model's ready.
module tb_reg_scoreboard;

  logic        clock;
  logic        reset;
  logic        issue_valid;
  logic [4:0]  issue_rs1;
  logic        issue_rs1_used;
  logic [4:0]  issue_rs2;
  logic        issue_rs2_used;
  logic [4:0]  issue_rd;
  logic        issue_rd_we;
  logic        issue_ready;
  logic        stall;
  logic        retire_valid;
  logic [4:0]  retire_rd;
  logic        flush;
  logic [31:0] busy_vector;
  logic [7:0]  pending_total;
  logic        err_sticky;
  logic [31:0] stall_cycles;

  reg_scoreboard dut (
    .clock(clock), .reset(reset),
    .issue_valid(issue_valid), .issue_rs1(issue_rs1), .issue_rs1_used(issue_rs1_used),
    .issue_rs2(issue_rs2), .issue_rs2_used(issue_rs2_used),
    .issue_rd(issue_rd), .issue_rd_we(issue_rd_we),
    .issue_ready(issue_ready), .stall(stall),
    .retire_valid(retire_valid), .retire_rd(retire_rd), .flush(flush),
    .busy_vector(busy_vector), .pending_total(pending_total),
    .err_sticky(err_sticky), .stall_cycles(stall_cycles)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: how many writes each register is still waiting for.
  int          m_cnt [32];
  bit          m_err;
  longint      m_stats;
  logic        obs_ready;
  logic        obs_stall;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int eff(input int r);
    int c;
    if (r == 0) return 0;
    c = m_cnt[r];
    if (retire_valid && int'(retire_rd) == r && c > 0) c--;
    return c;
  endfunction

  function automatic logic [31:0] m_busy();
    logic [31:0] b = '0;
    for (int r = 1; r < 32; r++) b[r] = (m_cnt[r] > 0);
    return b;
  endfunction

  function automatic logic [31:0] m_pending();
    int s = 0;
    for (int r = 1; r < 32; r++) s += m_cnt[r];
    return 32'(s);
  endfunction

  function automatic logic [31:0] m_stall_cycles();
`ifdef REG_SCOREBOARD_STATS_EN
    return 32'(m_stats);
`else
    return 32'd0;
`endif
  endfunction

  task automatic idle();
    reset = 0; flush = 0;
    issue_valid = 0; issue_rs1 = 0; issue_rs1_used = 0;
    issue_rs2 = 0; issue_rs2_used = 0; issue_rd = 0; issue_rd_we = 0;
    retire_valid = 0; retire_rd = 0;
  endtask

  task automatic set_issue(input int rs1, input bit u1, input int rs2, input bit u2, input int rd, input bit we);
    issue_valid = 1;
    issue_rs1 = 5'(rs1); issue_rs1_used = u1;
    issue_rs2 = 5'(rs2); issue_rs2_used = u2;
    issue_rd  = 5'(rd);  issue_rd_we    = we;
  endtask

  // One clock: check combinational outputs, advance the model, check registered outputs.
  task automatic cycle();
    bit exp_ready;
    bit exp_stall;
    bit acc;
    @(negedge clock);
    exp_ready = !flush
              && !(issue_rs1_used && issue_rs1 != 0 && eff(int'(issue_rs1)) > 0)
              && !(issue_rs2_used && issue_rs2 != 0 && eff(int'(issue_rs2)) > 0)
              && !(issue_rd_we && issue_rd != 0 && eff(int'(issue_rd)) >= 3);
    exp_stall = issue_valid && !exp_ready;
    obs_ready = issue_ready;
    obs_stall = stall;
    check("issue_ready", {31'd0, issue_ready}, {31'd0, exp_ready});
    check("stall", {31'd0, stall}, {31'd0, exp_stall});
    acc = issue_valid && exp_ready;
    if (reset) begin
      foreach (m_cnt[r]) m_cnt[r] = 0;
      m_err = 0;
      m_stats = 0;
    end else if (flush) begin
      foreach (m_cnt[r]) m_cnt[r] = 0;
    end else begin
      if (retire_valid && retire_rd != 0) begin
        if (m_cnt[retire_rd] > 0) m_cnt[retire_rd]--;
        else m_err = 1;
      end
      if (acc && issue_rd_we && issue_rd != 0) m_cnt[issue_rd]++;
      if (exp_stall && m_stats < 64'hFFFF_FFFF) m_stats++;
    end
    @(posedge clock);
    #1;
    check("busy_vector", busy_vector, m_busy());
    check("pending_total", {24'd0, pending_total}, m_pending());
    check("err_sticky", {31'd0, err_sticky}, {31'd0, m_err});
    check("stall_cycles", stall_cycles, m_stall_cycles());
  endtask

  initial begin
    idle();
    reset = 1;
    repeat (2) @(posedge clock);
    #1;
    // Registered reset cycle through the model.
    cycle();
    reset = 0;
    check("reset_busy", busy_vector, 32'd0);
    check("reset_pending", {24'd0, pending_total}, 32'd0);

    // Reset mid-operation: cnt[5]=2 and an error pending.
    idle(); set_issue(0, 0, 0, 0, 5, 1); cycle(); cycle();
    idle(); retire_valid = 1; retire_rd = 9; cycle();
    check("pre_reset_err", {31'd0, err_sticky}, 32'd1);
    idle(); reset = 1; cycle();
    idle();
    check("mid_reset_busy", busy_vector, 32'd0);
    check("mid_reset_pending", {24'd0, pending_total}, 32'd0);
    check("mid_reset_err", {31'd0, err_sticky}, 32'd0);

    // RAW stall, then release through the retire bypass.
    idle(); set_issue(0, 0, 0, 0, 5, 1); cycle();
    idle(); set_issue(5, 1, 0, 0, 6, 1); cycle();
    check("raw_ready", {31'd0, obs_ready}, 32'd0);
    check("raw_stall", {31'd0, obs_stall}, 32'd1);
    retire_valid = 1; retire_rd = 5; cycle();
    check("raw_bypass_ready", {31'd0, obs_ready}, 32'd1);
    check("raw_busy5", {31'd0, busy_vector[5]}, 32'd0);
    check("raw_busy6", {31'd0, busy_vector[6]}, 32'd1);

    // x0 is never tracked and never stalls.
    idle(); reset = 1; cycle();
    for (int i = 0; i < 3; i++) begin
      idle(); set_issue(0, 0, 0, 0, 0, 1); cycle();
      check("x0_no_stall", {31'd0, obs_stall}, 32'd0);
    end
    idle(); set_issue(0, 1, 0, 1, 0, 1); cycle();
    check("x0_src_no_stall", {31'd0, obs_stall}, 32'd0);
    idle(); retire_valid = 1; retire_rd = 0; cycle();
    check("x0_busy", busy_vector, 32'd0);
    check("x0_err", {31'd0, err_sticky}, 32'd0);

    // WAW saturation at MAX_PENDING=3.
    for (int i = 0; i < 3; i++) begin
      idle(); set_issue(0, 0, 0, 0, 7, 1); cycle();
    end
    check("waw_pending3", {24'd0, pending_total}, 32'd3);
    idle(); set_issue(0, 0, 0, 0, 7, 1); cycle();
    check("waw_stall", {31'd0, obs_stall}, 32'd1);
    retire_valid = 1; retire_rd = 7; cycle();
    check("waw_bypass_ready", {31'd0, obs_ready}, 32'd1);
    check("waw_pending_held", {24'd0, pending_total}, 32'd3);

    // Underflow on an idle register.
    idle(); retire_valid = 1; retire_rd = 9; cycle();
    check("uf_err", {31'd0, err_sticky}, 32'd1);
    check("uf_busy9", {31'd0, busy_vector[9]}, 32'd0);
    check("uf_pending", {24'd0, pending_total}, 32'd3);

    // Flush discards the concurrent issue.
    idle(); set_issue(0, 0, 0, 0, 3, 1); cycle();
    check("fl_pending4", {24'd0, pending_total}, 32'd4);
    idle(); flush = 1; set_issue(0, 0, 0, 0, 3, 1); cycle();
    check("fl_ready", {31'd0, obs_ready}, 32'd0);
    check("fl_pending", {24'd0, pending_total}, 32'd0);
    check("fl_busy3", {31'd0, busy_vector[3]}, 32'd0);

    // Exactly ten stalled cycles.
    idle(); reset = 1; cycle();
    idle(); set_issue(0, 0, 0, 0, 5, 1); cycle();
    idle(); set_issue(5, 1, 0, 0, 0, 0);
    repeat (10) cycle();
`ifdef REG_SCOREBOARD_STATS_EN
    check("stats_ten", stall_cycles, 32'd10);
`else
    check("stats_tied", stall_cycles, 32'd0);
`endif

    // Randomized traffic on a narrow address window to provoke hazards.
    for (int i = 0; i < 2000; i++) begin
      idle();
      reset = ($urandom_range(0, 199) == 0);
      flush = ($urandom_range(0, 39) == 0);
      issue_valid    = ($urandom_range(0, 9) < 7);
      issue_rs1      = 5'($urandom_range(0, 7));
      issue_rs1_used = 1'($urandom);
      issue_rs2      = 5'($urandom_range(0, 7));
      issue_rs2_used = 1'($urandom);
      issue_rd       = 5'($urandom_range(0, 7));
      issue_rd_we    = ($urandom_range(0, 3) != 0);
      retire_valid   = !flush && ($urandom_range(0, 1) == 1);
      retire_rd      = 5'($urandom_range(0, 7));
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
